// File: rtl/memory_access_pkg.sv
// memory_access_pkg: MEM control bit indices and access-size codes shared by the ID decoder and the MEM stage
package memory_access_pkg;
  localparam int RD      = 4;
  localparam int WR      = 3;
  localparam int SIZE_HI = 2;
  localparam int SIZE_LO = 1;
  localparam int UNS     = 0;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_ILL  = 2'b10,
    SZ_WORD = 2'b11
  } size_e;
endpackage

// File: rtl/memory_access_data_ram.sv
// memory_access_data_ram: 2**NB_ADDR x NB_REG RAM; byte-enabled write (i_we/i_addr/i_wdata), sync pipeline read (i_rd_en -> o_rd_data), sync debug read (i_debug_addr -> o_debug_data)
module memory_access_data_ram #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 10
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_REG/8-1:0]   i_we,
  input  logic                  i_rd_en,
  input  logic [NB_ADDR-1:0]    i_addr,
  input  logic [NB_REG-1:0]     i_wdata,
  input  logic [NB_ADDR-1:0]    i_debug_addr,
  output logic [NB_REG-1:0]     o_rd_data,
  output logic [NB_REG-1:0]     o_debug_data
);
  logic [NB_REG-1:0] mem [2**NB_ADDR];
  always_ff @(posedge i_clock)
    for (int i = 0; i < NB_REG/8; i++)
      if (i_we[i]) mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      o_rd_data    <= '0;
      o_debug_data <= '0;
    end else begin
      if (i_rd_en) o_rd_data <= mem[i_addr];
      o_debug_data <= mem[i_debug_addr];
    end
endmodule

// File: rtl/memory_access.sv
// memory_access: MIPS MEM stage; EX/MEM in (i_valid,i_alu,i_b,i_mem,i_wb,i_pc), MEM/WB out (o_read_data,o_alu,o_wb,o_pc,o_misaligned), debug read (i_debug_addr -> o_debug_data)
module memory_access
  import memory_access_pkg::*;
#(
  parameter int NB_REG  = 32,
  parameter int NB_MEM  = 5,
  parameter int NB_WB   = 8,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_REG-1:0]  i_alu,
  input  logic [NB_REG-1:0]  i_b,
  input  logic [NB_MEM-1:0]  i_mem,
  input  logic [NB_WB-1:0]   i_wb,
  input  logic [NB_REG-1:0]  i_pc,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic [NB_REG-1:0]  o_read_data,
  output logic [NB_REG-1:0]  o_alu,
  output logic [NB_WB-1:0]   o_wb,
  output logic [NB_REG-1:0]  o_pc,
  output logic               o_misaligned,
  output logic [NB_REG-1:0]  o_debug_data
);
  size_e sz, sz_q;
  logic rd, wr, mis, ld_q, uns_q;
  logic [1:0] lane, lane_q;
  logic [3:0] be, we;
  logic [7:0] b8;
  logic [15:0] h16;
  logic [NB_REG-1:0] wdata, ram_q;
  assign rd   = i_mem[RD];
  assign wr   = i_mem[WR];
  assign sz   = size_e'(i_mem[SIZE_HI:SIZE_LO]);
  assign lane = i_alu[1:0];
  assign mis  = (rd || wr) && (sz == SZ_ILL || (sz == SZ_HALF && lane[0]) || (sz == SZ_WORD && lane != 2'b00));
  always_comb begin
    be    = sz == SZ_BYTE ? 4'b0001 << lane : sz == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = sz == SZ_BYTE ? {4{i_b[7:0]}} : sz == SZ_HALF ? {2{i_b[15:0]}} : i_b;
    // reset gating keeps a store pending across an asynchronous reset from committing
    we    = (i_valid && wr && !mis && !i_reset) ? be : 4'b0000;
  end
  memory_access_data_ram #(.NB_REG(NB_REG), .NB_ADDR(NB_ADDR)) u_ram (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_we         (we),
    .i_rd_en      (i_valid),
    .i_addr       (i_alu[NB_ADDR+1:2]),
    .i_wdata      (wdata),
    .i_debug_addr (i_debug_addr),
    .o_rd_data    (ram_q),
    .o_debug_data (o_debug_data)
  );
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      o_alu        <= '0;
      o_wb         <= '0;
      o_pc         <= '0;
      o_misaligned <= 1'b0;
      ld_q         <= 1'b0;
      lane_q       <= 2'b00;
      sz_q         <= SZ_BYTE;
      uns_q        <= 1'b0;
    end else if (i_valid) begin
      o_alu        <= i_alu;
      o_wb         <= i_wb;
      o_pc         <= i_pc;
      o_misaligned <= mis;
      ld_q         <= rd && !wr && !mis;
      lane_q       <= lane;
      sz_q         <= sz;
      uns_q        <= i_mem[UNS];
    end
  always_comb begin
    b8          = ram_q[{lane_q, 3'b000} +: 8];
    h16         = lane_q[1] ? ram_q[31:16] : ram_q[15:0];
    o_read_data = !ld_q ? '0
                : sz_q == SZ_BYTE ? {{(NB_REG-8){!uns_q && b8[7]}}, b8}
                : sz_q == SZ_HALF ? {{(NB_REG-16){!uns_q && h16[15]}}, h16}
                : ram_q;
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized and directed check of memory_access against a byte-array reference model
module tb_memory_access;
  localparam logic [4:0] SW = 5'b01110, SH = 5'b01010, SB = 5'b01000;
  localparam logic [4:0] LW = 5'b10110, LH = 5'b10010, LHU = 5'b10011, LB = 5'b10000, LBU = 5'b10001;
  logic i_clock = 0, i_reset = 1, i_valid = 0;
  logic [31:0] i_alu = 0, i_b = 0, i_pc = 0;
  logic [4:0] i_mem = 0;
  logic [7:0] i_wb = 0;
  logic [9:0] i_debug_addr = 0;
  logic [31:0] o_read_data, o_alu, o_pc, o_debug_data;
  logic [7:0] o_wb;
  logic o_misaligned;
  memory_access dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_alu(i_alu), .i_b(i_b),
    .i_mem(i_mem), .i_wb(i_wb), .i_pc(i_pc), .i_debug_addr(i_debug_addr),
    .o_read_data(o_read_data), .o_alu(o_alu), .o_wb(o_wb), .o_pc(o_pc),
    .o_misaligned(o_misaligned), .o_debug_data(o_debug_data)
  );
  always #5 i_clock = ~i_clock;
  int n_checks = 0, n_fail = 0;
  logic [7:0] mb [4096];
  bit known [1024];
  logic [31:0] e_rd = 0, e_alu = 0, e_pc = 0;
  logic [7:0] e_wb = 0;
  logic e_mis = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] word_at(int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction
  task automatic check_outs(string tag);
    check({tag, "_read_data"}, o_read_data, e_rd);
    check({tag, "_alu"}, o_alu, e_alu);
    check({tag, "_wb"}, {24'h0, o_wb}, {24'h0, e_wb});
    check({tag, "_pc"}, o_pc, e_pc);
    check({tag, "_misaligned"}, {31'h0, o_misaligned}, {31'h0, e_mis});
  endtask
  task automatic tick(bit v, logic [31:0] a, logic [31:0] b, logic [4:0] m, logic [9:0] dbg);
    int n, ba;
    logic [31:0] val, e_dbg;
    bit mis, dk;
    logic [7:0] wb = 8'($urandom);
    logic [31:0] pc = $urandom;
    i_valid = v; i_alu = a; i_b = b; i_mem = m; i_wb = wb; i_pc = pc; i_debug_addr = dbg;
    dk = known[dbg];
    e_dbg = word_at(int'(dbg));
    if (v) begin
      n = m[2:1] == 2'd0 ? 1 : m[2:1] == 2'd1 ? 2 : m[2:1] == 2'd3 ? 4 : 0;
      ba = int'(a[11:0]);
      mis = (m[4] || m[3]) && (n == 0 || ba % n != 0);
      val = 0;
      for (int k = 0; k < n; k++) val |= 32'(mb[ba+k]) << (8*k);
      if (!m[0] && n > 0 && n < 4 && val[8*n-1]) val |= 32'hFFFFFFFF << (8*n);
      e_rd = (m[4] && !m[3] && !mis) ? val : 32'h0;
      e_alu = a; e_wb = wb; e_pc = pc; e_mis = mis;
      if (m[3] && !mis) begin
        for (int k = 0; k < n; k++) mb[ba+k] = 8'(b >> (8*k));
        if (n == 4) known[ba/4] = 1;
      end
    end
    @(posedge i_clock);
    #1;
    check_outs("tick");
    if (dk) check("debug_data", o_debug_data, e_dbg);
  endtask
  initial begin
    #3;
    check_outs("reset");
    check("reset_debug", o_debug_data, 32'h0);
    @(negedge i_clock);
    i_reset = 0;
    for (int w = 0; w < 1024; w++)
      tick(1, 32'(w*4), $urandom, SW, 10'(w == 0 ? 0 : w - 1));
    tick(1, 32'h10, 32'hDEADBEEF, SW, 0);
    tick(1, 32'h10, 0, LW, 0);
    check("lw_deadbeef", o_read_data, 32'hDEADBEEF);
    tick(1, 32'h13, 32'h80, SB, 0);
    tick(1, 32'h13, 0, LB, 0);
    check("lb_80", o_read_data, 32'hFFFFFF80);
    tick(1, 32'h13, 0, LBU, 0);
    check("lbu_80", o_read_data, 32'h00000080);
    tick(1, 32'h10, 0, LW, 0);
    check("lw_after_sb", o_read_data, 32'h80ADBEEF);
    tick(1, 32'h22, 32'h8001, SH, 0);
    tick(1, 32'h22, 0, LH, 0);
    check("lh_8001", o_read_data, 32'hFFFF8001);
    tick(1, 32'h22, 0, LHU, 0);
    check("lhu_8001", o_read_data, 32'h00008001);
    tick(1, 32'h20, 0, LW, 0);
    check("lw_upper_half", {16'h0, o_read_data[31:16]}, 32'h8001);
    tick(1, 32'h06, 0, LW, 1);
    check("lw_misaligned", {31'h0, o_misaligned}, 32'h1);
    check("lw_misaligned_data", o_read_data, 32'h0);
    tick(1, 32'h05, 32'hFFFF, SH, 1);
    check("sh_misaligned", {31'h0, o_misaligned}, 32'h1);
    tick(1, 32'h04, 0, LW, 1);
    tick(0, 32'h10, 32'h12345678, SW, 4);
    check("hold_alu", o_alu, 32'h04);
    tick(1, 32'h10, 0, LW, 4);
    check("no_write_when_invalid", o_read_data, 32'h80ADBEEF);
    tick(1, 32'h1010, 0, LW, 4);
    check("alias_lw", o_read_data, 32'h80ADBEEF);
    check("debug_word4", o_debug_data, 32'h80ADBEEF);
    i_valid = 1; i_alu = 32'h10; i_b = 32'hCAFEF00D; i_mem = SW;
    #2;
    i_reset = 1;
    #1;
    e_rd = 0; e_alu = 0; e_wb = 0; e_pc = 0; e_mis = 0;
    check_outs("async_reset");
    check("async_reset_debug", o_debug_data, 32'h0);
    @(posedge i_clock);
    #1;
    check_outs("reset_held");
    #2;
    i_reset = 0;
    tick(1, 32'h10, 0, LW, 4);
    check("store_dropped_by_reset", o_read_data, 32'h80ADBEEF);
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 7) != 0, $urandom & 32'hFFFFF03F, $urandom, 5'($urandom_range(0, 31)), 10'($urandom_range(0, 15)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
